// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver with glitch-rejecting start detect and output FIFO.
// Optional saturating error counters are enabled by defining UART_RX_ERRCNT_EN.
module uart_rx_fifo #(
    parameter int CLK_DIV    = 217,
    parameter int OVERSAMPLE = 4,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_perr,
    output logic                 frame_err,
    output logic                 overflow
`ifdef UART_RX_ERRCNT_EN
    ,
    output logic [15:0]          frame_err_cnt,
    output logic [15:0]          parity_err_cnt,
    output logic [15:0]          overflow_cnt
`endif
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT
    } state_t;

    state_t               state_q, state_d;
    logic                 rx_m_q, rx_s_q;
    logic [1:0]           warm_q;
    logic                 armed_q;
    logic [DW-1:0]        div_q;
    logic [TW-1:0]        tick_q;
    logic                 div_end, sample;
    logic [TW-1:0]        lim;
    logic [3:0]           bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 perr_q, perr_d;
    logic                 push_q, push_d;
    logic                 ferr_q, ferr_d;

    logic [DATA_BITS:0]   mem_q [FIFO_DEPTH];
    logic [AW:0]          wptr_q, wptr_d, rptr_q, rptr_d;
    logic                 full, pop, do_push, ovf_d, ovf_q;
    logic [DATA_BITS:0]   head;
    logic                 vld_d, vld_q;
    logic [DATA_BITS-1:0] odata_q;
    logic                 operr_q;

    // Two-FF synchroniser; arming waits until the preset values are flushed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m_q  <= 1'b1;
            rx_s_q  <= 1'b1;
            warm_q  <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            rx_m_q <= rx;
            rx_s_q <= rx_m_q;
            warm_q <= {warm_q[0], 1'b1};
            if (warm_q[1] && rx_s_q)
                armed_q <= 1'b1;
        end
    end

    assign div_end = (div_q == DW'(CLK_DIV - 1));
    assign lim     = (state_q == S_START) ? TW'(OVERSAMPLE/2 - 1)
                                          : TW'(OVERSAMPLE - 1);
    assign sample  = div_end && (tick_q == lim) &&
                     (state_q != S_IDLE) && (state_q != S_WAIT);

    // Prescaler and tick counter; restart after every sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= '0;
            tick_q <= '0;
        end else if (state_q == S_IDLE || state_q == S_WAIT || sample) begin
            div_q  <= '0;
            tick_q <= '0;
        end else if (div_end) begin
            div_q  <= '0;
            tick_q <= tick_q + TW'(1);
        end else begin
            div_q <= div_q + DW'(1);
        end
    end

    // Frame FSM next-state logic
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        data_d  = data_q;
        perr_d  = perr_q;
        push_d  = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (armed_q && !rx_s_q) begin
                    state_d = S_START;
                    bit_d   = '0;
                    stop_d  = 1'b0;
                    perr_d  = 1'b0;
                end
            end
            S_START: begin
                if (sample)
                    state_d = rx_s_q ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (sample) begin
                    data_d = {rx_s_q, data_q[DATA_BITS-1:1]};
                    bit_d  = bit_q + 4'd1;
                    if (bit_q == 4'(DATA_BITS - 1))
                        state_d = (PARITY != 0) ? S_PAR : S_STOP;
                end
            end
            S_PAR: begin
                if (sample) begin
                    perr_d  = (PARITY == 1) ? ~(^data_q ^ rx_s_q)
                                            : (^data_q ^ rx_s_q);
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (sample) begin
                    if (!rx_s_q) begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT;
                    end else if (stop_q == 1'(STOP_BITS - 1)) begin
                        push_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (rx_s_q)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Frame FSM registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            data_q  <= '0;
            perr_q  <= 1'b0;
            push_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            data_q  <= data_d;
            perr_q  <= perr_d;
            push_q  <= push_d;
            ferr_q  <= ferr_d;
        end
    end

    // FIFO control; head register reflects the post-update FIFO contents
    always_comb begin
        pop     = vld_q && out_ready;
        full    = ((wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}});
        do_push = push_q && (!full || pop);
        ovf_d   = push_q && full && !pop;
        wptr_d  = wptr_q + {{AW{1'b0}}, do_push};
        rptr_d  = rptr_q + {{AW{1'b0}}, pop};
        vld_d   = (wptr_d != rptr_d);
        if (do_push && (rptr_d[AW-1:0] == wptr_q[AW-1:0]))
            head = {perr_q, data_q};
        else
            head = mem_q[rptr_d[AW-1:0]];
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wptr_q[AW-1:0]] <= {perr_q, data_q};
    end

    // FIFO pointers, registered head and pulse outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            vld_q   <= 1'b0;
            odata_q <= '0;
            operr_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            vld_q  <= vld_d;
            ovf_q  <= ovf_d;
            if (vld_d)
                {operr_q, odata_q} <= head;
        end
    end

    assign out_valid = vld_q;
    assign out_data  = odata_q;
    assign out_perr  = operr_q;
    assign frame_err = ferr_q;
    assign overflow  = ovf_q;

`ifdef UART_RX_ERRCNT_EN
    logic [15:0] fe_cnt_q, pe_cnt_q, ov_cnt_q;

    // Saturating error counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fe_cnt_q <= '0;
            pe_cnt_q <= '0;
            ov_cnt_q <= '0;
        end else begin
            if (ferr_q && fe_cnt_q != 16'hFFFF)
                fe_cnt_q <= fe_cnt_q + 16'd1;
            if (do_push && perr_q && pe_cnt_q != 16'hFFFF)
                pe_cnt_q <= pe_cnt_q + 16'd1;
            if (ovf_q && ov_cnt_q != 16'hFFFF)
                ov_cnt_q <= ov_cnt_q + 16'd1;
        end
    end

    assign frame_err_cnt  = fe_cnt_q;
    assign parity_err_cnt = pe_cnt_q;
    assign overflow_cnt   = ov_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised scoreboard bench for uart_rx_fifo.
// Sim setup: CLK_DIV=4, OVERSAMPLE=4, 8N1 main DUT plus an 8E1 DUT.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rx2 = 1'b1;
    logic       rdy_man = 1'b1;
    logic       rdy_rnd = 1'b1;
    logic       rnd_mode = 1'b0;
    logic       out_ready;
    logic       out_ready2 = 1'b0;
    logic       out_valid, out_perr, frame_err, overflow;
    logic [7:0] out_data;
    logic       out_valid2, out_perr2, frame_err2, overflow2;
    logic [7:0] out_data2;

    int nvec = 0;
    int nerr = 0;
    int fe_seen = 0;
    int ov_seen = 0;
    logic [7:0] exp_q[$];

    assign out_ready = rnd_mode ? rdy_rnd : rdy_man;

    uart_rx_fifo #(.CLK_DIV(4), .OVERSAMPLE(4), .DATA_BITS(8),
                   .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_perr(out_perr),
        .frame_err(frame_err), .overflow(overflow)
    );

    uart_rx_fifo #(.CLK_DIV(4), .OVERSAMPLE(4), .DATA_BITS(8),
                   .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .rst(rst), .rx(rx2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_data(out_data2), .out_perr(out_perr2),
        .frame_err(frame_err2), .overflow(overflow2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One bit period is 16 clocks
    task automatic txbit(input int ch, input logic v);
        if (ch == 0) rx = v;
        else rx2 = v;
        repeat (16) @(posedge clk);
        #1;
    endtask

    // Start, 8 data bits LSB first, optional parity, one stop bit
    task automatic send(input int ch, input logic [7:0] d,
                        input int par, input logic stopv);
        txbit(ch, 1'b0);
        for (int i = 0; i < 8; i++) txbit(ch, d[i]);
        if (par >= 0) txbit(ch, par[0]);
        txbit(ch, stopv);
    endtask

    always @(posedge clk) begin
        #1;
        rdy_rnd = 1'($urandom_range(0, 1));
    end

    // Scoreboard: every accepted head must match the oldest expected byte
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) fe_seen++;
            if (overflow) ov_seen++;
            if (frame_err && overflow) chk("err_both", 1, 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("pop_unexpected", exp_q.size(), 1);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    chk("pop_data", out_data, e);
                    chk("pop_perr", out_perr, 0);
                end
            end
        end
    end

    // Parity DUT: send one frame, wait bounded for the head, check and pop
    task automatic par_frame(input logic [7:0] d, input logic p);
        logic eperr;
        bit   got;
        eperr = 1'(($countones(d) + int'(p)) % 2);
        send(1, d, int'(p), 1'b1);
        txbit(1, 1'b1);
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (out_valid2) got = 1;
        end
        chk("par_valid", got, 1);
        chk("par_data", out_data2, d);
        chk("par_perr", out_perr2, eperr);
        @(posedge clk); #1;
        out_ready2 = 1'b1;
        @(posedge clk); #1;
        out_ready2 = 1'b0;
    endtask

    initial begin
        int fe0, ov0, efe, eov;
        logic [7:0] d;
        logic bad;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_perr", out_perr, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovf", overflow, 0);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        fe0 = fe_seen; ov0 = ov_seen;
        exp_q.push_back(8'hA5);
        send(0, 8'hA5, -1, 1'b1);
        txbit(0, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        chk("a5_drained", exp_q.size(), 0);
        chk("a5_ferr", fe_seen - fe0, 0);
        chk("a5_ovf", ov_seen - ov0, 0);

        par_frame(8'h03, 1'b1);
        par_frame(8'h03, 1'b0);

        fe0 = fe_seen;
        rx = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        chk("glitch_valid", out_valid, 0);
        chk("glitch_ferr", fe_seen - fe0, 0);

        fe0 = fe_seen;
        send(0, 8'h55, -1, 1'b0);
        rx = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("brk_ferr", fe_seen - fe0, 1);
        chk("brk_valid", out_valid, 0);

        ov0 = ov_seen; eov = 0;
        rdy_man = 1'b0;
        for (int b = 1; b <= 5; b++) begin
            if (exp_q.size() < 4) exp_q.push_back(8'(b));
            else eov++;
            send(0, 8'(b), -1, 1'b1);
            txbit(0, 1'b1);
        end
        repeat (10) @(posedge clk);
        #1;
        chk("ovf_pulses", ov_seen - ov0, eov);
        chk("ovf_held", out_valid, 1);
        rdy_man = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("ovf_drained", exp_q.size(), 0);

        ov0 = ov_seen;
        rdy_man = 1'b0;
        for (int b = 1; b <= 4; b++) begin
            exp_q.push_back(8'(b));
            send(0, 8'(b), -1, 1'b1);
            txbit(0, 1'b1);
        end
        exp_q.push_back(8'h05);
        fork
            send(0, 8'h05, -1, 1'b1);
            begin
                repeat (155) @(posedge clk);
                #1;
                rdy_man = 1'b1;
                @(posedge clk);
                #1;
                rdy_man = 1'b0;
            end
        join
        txbit(0, 1'b1);
        chk("pp_ovf", ov_seen - ov0, 0);
        rdy_man = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("pp_drained", exp_q.size(), 0);

        fe0 = fe_seen;
        txbit(0, 1'b0);
        txbit(0, 1'b0);
        txbit(0, 1'b1);
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ferr", frame_err, 0);
        exp_q.delete();
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_ferr", fe_seen - fe0, 0);
        exp_q.push_back(8'h7E);
        send(0, 8'h7E, -1, 1'b1);
        txbit(0, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_7e", exp_q.size(), 0);

        fe0 = fe_seen; ov0 = ov_seen; efe = 0;
        rnd_mode = 1'b1;
        for (int n = 0; n < 24; n++) begin
            d = 8'($urandom);
            bad = ($urandom_range(0, 7) == 0);
            if (bad) efe++;
            else exp_q.push_back(d);
            send(0, d, -1, !bad);
            txbit(0, 1'b1);
            repeat ($urandom_range(0, 30)) @(posedge clk);
            #1;
        end
        rnd_mode = 1'b0;
        rdy_man = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("rnd_drained", exp_q.size(), 0);
        chk("rnd_ferr", fe_seen - fe0, efe);
        chk("rnd_ovf", ov_seen - ov0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
